dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter RegBits, default 32, data word width.
REQ-002 SHALL have parameter AddrBits, default 10, word-address width (1024-word memory).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports req_valid_i[1:0], input, 2, per-requester request valid (index 0 = core LSU, 1 = loader/debug).
REQ-006 SHALL have ports req_ready_o[1:0], output, 2, per-requester accept.
REQ-007 SHALL have ports req_we_i[1:0], input, 2, write (1) / read (0).
REQ-008 SHALL have ports req_addr_i[2][AddrBits], input, per-requester word address.
REQ-009 SHALL have ports req_wdata_i[2][RegBits], input, write data.
REQ-010 SHALL have ports req_be_i[2][RegBits/8], input, byte enables.
REQ-011 SHALL have ports rsp_valid_o[1:0], output, 2, one-cycle completion pulse per requester.
REQ-012 SHALL have port rsp_rdata_o, output, RegBits, registered read data, shared by both requesters.
REQ-013 SHALL have ports mem_a_o (AddrBits, out), mem_wd_o (RegBits, out), mem_we_o (1, out), mem_rd_i (RegBits, in, combinational read of mem_a_o).

Function
REQ-014 SHALL use FSM states IDLE and RMW; IDLE->RMW on accepting a partial write; RMW->IDLE unconditionally after one cycle.
REQ-015 SHALL, in IDLE, assert req_ready_o for exactly one requester with valid set (the grant) and for none otherwise; in RMW, deassert both.
REQ-016 SHALL consider a request accepted when its valid and ready are both high in the same cycle T.
REQ-017 SHALL, for an accepted read at T, drive mem_a_o = addr at T, register mem_rd_i into rsp_rdata_o, and pulse rsp_valid_o[grant] at T+1.
REQ-018 SHALL, for an accepted write with all byte enables set, assert mem_we_o with mem_wd_o = wdata at T and pulse rsp_valid_o at T+1.
REQ-019 SHALL, for a partial write (some but not all enables set), at T latch mem_rd_i, merge wdata into enabled bytes, enter RMW; at T+1 drive the same address with mem_we_o and the merged word; pulse rsp_valid_o at T+2.
REQ-020 SHALL treat a write with all enables clear as a no-op: no mem_we_o, rsp_valid_o at T+1.
REQ-021 SHALL leave rsp_rdata_o unchanged on writes and hold it until the next read completes.
REQ-022 SHALL sustain one read or full write per cycle back-to-back; a partial write costs two cycles.
REQ-023 SHALL keep mem_we_o low whenever no full write is accepted in IDLE and not in RMW.
REQ-024 SHALL latch the requester id, address and merged data at acceptance so requester inputs may change from T+1.

Reset
REQ-025 SHALL on rst_i force IDLE, rsp_valid_o = 0, rsp_rdata_o = 0, mem_we_o = 0, round-robin pointer to favour requester 0.
REQ-026 SHALL abort an RMW in progress on reset: no memory write, no rsp_valid_o pulse.

Configuration
REQ-027 SHALL, with DMEM_ARB_RR_EN defined, grant round-robin: on contention grant the requester not granted most recently; pointer updates only on acceptance.
REQ-028 SHALL, without DMEM_ARB_RR_EN, grant fixed priority: requester 0 always wins contention.

Structure
REQ-029 SHALL place the FSM state enum and a request struct (we, addr, wdata, be) in shared package dmem_pkg.
REQ-030 SHALL implement byte merging in sub-module dmem_byte_merge (old word, new word, enables -> merged word, combinational).

Verification
REQ-031 Read: mem[5]=32'hDEADBEEF, req0 read addr 5 at T -> rsp_valid_o[0] at T+1, rsp_rdata_o=32'hDEADBEEF.
REQ-032 Partial write: mem[7]=32'h11223344, req1 write 32'hAABBCCDD be=4'b0101 -> mem_we_o at T+1 only, mem[7]=32'h11BB33DD, rsp_valid_o[1] at T+2, both ready low at T+1.
REQ-033 Contention: both valid for 4 cycles with full-word reads -> with DMEM_ARB_RR_EN grants 0,1,0,1; without it 0,0,0,0.
REQ-034 Back-to-back: req0 full writes addr 1,2,3 on consecutive cycles -> three mem_we_o cycles, three rsp_valid_o[0] pulses, no bubbles.
REQ-035 Reset mid-RMW: partial write to addr 9 accepted, rst_i high at T+1 -> mem[9] unchanged, no rsp_valid_o, state IDLE after reset.
REQ-036 Zero enables: req0 write be=4'b0000 -> mem_we_o never high, rsp_valid_o[0] at T+1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types for the data-memory arbiter: FSM state encoding, the request
// bundle carried from the selected requester into the datapath, and a small
// helper that turns a requester id into a one-hot strobe.
// Build option: DMEM_ARB_RR_EN (consumed in dmem_arbiter) selects round-robin
// arbitration; the package itself is identical in both builds.
package dmem_pkg;

  localparam int unsigned DMEM_REG_BITS  = 32;
  localparam int unsigned DMEM_ADDR_BITS = 10;

  // Legacy-compatible state constants; the enum below reuses their values.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RMW  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RMW  = ST_RMW
  } dmem_state_e;

  // Fields are sized by the package widths, so the arbiter parameters are
  // expected to stay at these values when this struct is used.
  typedef struct packed {
    logic                          we;
    logic [DMEM_ADDR_BITS-1:0]     addr;
    logic [DMEM_REG_BITS-1:0]      wdata;
    logic [DMEM_REG_BITS/8-1:0]    be;
  } dmem_req_t;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge
// Combinational byte-lane merge used by the read-modify-write path.
// Ports:
//   old_word - word currently stored in memory
//   new_word - write data from the requester
//   be       - byte enables; a set bit takes that byte from new_word
//   merged   - resulting word to be written back
module dmem_byte_merge #(
  parameter int unsigned RegBits = 32
) (
  input  logic [RegBits-1:0]   old_word,
  input  logic [RegBits-1:0]   new_word,
  input  logic [RegBits/8-1:0] be,
  output logic [RegBits-1:0]   merged
);

  // Start from the stored word and overlay only the enabled byte lanes.
  always_comb begin
    merged = old_word;
    for (int b = 0; b < RegBits / 8; b++) begin
      if (be[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-port, combinational-read data
// memory. Reads and full-word writes complete in one cycle; partial writes
// take an extra read-modify-write cycle.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   req_valid_i/req_ready_o - per-requester handshake (0 = core LSU, 1 = loader)
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i   - per-requester request fields
//   rsp_valid_o             - one-cycle completion pulse per requester
//   rsp_rdata_o             - registered read data, shared by both requesters
//   mem_a_o, mem_wd_o,
//   mem_we_o, mem_rd_i      - memory port (mem_rd_i is a combinational read)
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RegBits  = DMEM_REG_BITS,
  parameter int unsigned AddrBits = DMEM_ADDR_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [AddrBits-1:0]   req_addr_i  [2],
  input  logic [RegBits-1:0]    req_wdata_i [2],
  input  logic [RegBits/8-1:0]  req_be_i    [2],
  output logic [1:0]            rsp_valid_o,
  output logic [RegBits-1:0]    rsp_rdata_o,
  output logic [AddrBits-1:0]   mem_a_o,
  output logic [RegBits-1:0]    mem_wd_o,
  output logic                  mem_we_o,
  input  logic [RegBits-1:0]    mem_rd_i
);

  dmem_state_e          state;
  logic                 grant_id;
  logic                 accept;
  dmem_req_t            sel;
  logic                 is_full;
  logic                 is_none;
  logic                 is_partial;
  logic [RegBits-1:0]   merged;
  logic                 pend_id;
  logic [AddrBits-1:0]  pend_addr;
  logic [RegBits-1:0]   pend_data;
  logic [1:0]           rsp_valid;
  logic [RegBits-1:0]   rsp_rdata;
`ifdef DMEM_ARB_RR_EN
  logic                 last_id;
`endif

  // Pick the requester to serve. A lone requester always wins; on contention
  // the choice depends on the build option.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid_i == 2'b10) begin
      grant_id = 1'b1;
    end
`ifdef DMEM_ARB_RR_EN
    else if (req_valid_i == 2'b11) begin
      grant_id = ~last_id;
    end
`endif
  end

  // Nothing is accepted while the RMW write-back owns the memory port or
  // while reset is asserted, so no request is silently lost.
  assign accept      = (state == IDLE) && (req_valid_i != 2'b00) && !rst_i;
  assign req_ready_o = accept ? id_to_onehot(grant_id) : 2'b00;

  // Route the granted requester's fields into the datapath.
  always_comb begin
    sel.we    = req_we_i[grant_id];
    sel.addr  = req_addr_i[grant_id];
    sel.wdata = req_wdata_i[grant_id];
    sel.be    = req_be_i[grant_id];
  end

  assign is_full    = &sel.be;
  assign is_none    = ~|sel.be;
  assign is_partial = !is_full && !is_none;

  // In IDLE the memory is addressed by the granted request, so mem_rd_i is
  // the old word needed for a partial-write merge.
  dmem_byte_merge #(.RegBits(RegBits)) u_merge (
    .old_word (mem_rd_i),
    .new_word (sel.wdata),
    .be       (sel.be),
    .merged   (merged)
  );

  // Memory port: the latched RMW write-back takes priority over the live
  // request. Reset suppresses any write, which also aborts a pending RMW.
  assign mem_a_o  = (state == RMW) ? pend_addr : sel.addr;
  assign mem_wd_o = (state == RMW) ? pend_data : sel.wdata;
  assign mem_we_o = !rst_i && ((state == RMW) || (accept && sel.we && is_full));

  assign rsp_valid_o = rsp_valid;
  assign rsp_rdata_o = rsp_rdata;

  // Sequencing: single-cycle completion for reads, full and empty writes;
  // partial writes latch id, address and merged word and spend one RMW cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      pend_id   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
`ifdef DMEM_ARB_RR_EN
      last_id   <= 1'b1;
`endif
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel.we && is_partial) begin
              state     <= RMW;
              pend_id   <= grant_id;
              pend_addr <= sel.addr;
              pend_data <= merged;
            end else begin
              rsp_valid <= id_to_onehot(grant_id);
              if (!sel.we) begin
                rsp_rdata <= mem_rd_i;
              end
            end
`ifdef DMEM_ARB_RR_EN
            last_id <= grant_id;
`endif
          end
        end
        RMW: begin
          state     <= IDLE;
          rsp_valid <= id_to_onehot(pend_id);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Randomised and directed stimulus against a transaction-level reference of
// the arbiter: a shadow memory, an arbitration rule and a response queue.
module tb_dmem_arbiter;

  localparam int RB = 32;
  localparam int AB = 10;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [1:0]     req_valid_i;
  logic [1:0]     req_ready_o;
  logic [1:0]     req_we_i;
  logic [AB-1:0]  req_addr_i  [2];
  logic [RB-1:0]  req_wdata_i [2];
  logic [3:0]     req_be_i    [2];
  logic [1:0]     rsp_valid_o;
  logic [RB-1:0]  rsp_rdata_o;
  logic [AB-1:0]  mem_a_o;
  logic [RB-1:0]  mem_wd_o;
  logic           mem_we_o;
  logic [RB-1:0]  mem_rd_i;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  typedef struct {
    int          id;
    int          due;
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  bit          o_busy = 0;
  bit          o_pend = 0;
  int          o_pid = 0;
  logic [9:0]  o_paddr = '0;
  logic [31:0] o_pdata = '0;
  int          o_last = 1;
  logic [31:0] last_rdata = '0;

  dmem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_a_o     (mem_a_o),
    .mem_wd_o    (mem_wd_o),
    .mem_we_o    (mem_we_o),
    .mem_rd_i    (mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural memory attached to the DUT's memory port.
  assign mem_rd_i = mem[mem_a_o];
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_a_o] <= mem_wd_o;
  end

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [31:0] refMerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return r;
  endfunction

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] we,
                               input logic [9:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                               input logic [9:0] a1, input logic [31:0] d1, input logic [3:0] b1);
    @(posedge clk_i);
    #1;
    rst_i          = r;
    req_valid_i    = v;
    req_we_i       = we;
    req_addr_i[0]  = a0;
    req_wdata_i[0] = d0;
    req_be_i[0]    = b0;
    req_addr_i[1]  = a1;
    req_wdata_i[1] = d1;
    req_be_i[1]    = b1;
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(r, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
  endtask

  // Reference model: decides who should be granted, what the memory port must
  // do this cycle, and queues the expected completion for accepted requests.
  always @(negedge clk_i) begin
    logic [1:0]  exp_ready;
    bit          exp_we;
    logic [9:0]  exp_a;
    logic [31:0] exp_d;
    int          id;
    if (cycle > 0) begin
      exp_ready = 2'b00;
      if (!rst_i && !o_busy) begin
        case (req_valid_i)
          2'b01: exp_ready = 2'b01;
          2'b10: exp_ready = 2'b10;
          2'b11: begin
`ifdef DMEM_ARB_RR_EN
            exp_ready = (o_last == 1) ? 2'b01 : 2'b10;
`else
            exp_ready = 2'b01;
`endif
          end
          default: exp_ready = 2'b00;
        endcase
      end
      checkOutput("req_ready", {30'd0, req_ready_o}, {30'd0, exp_ready});

      exp_we = 0;
      exp_a  = '0;
      exp_d  = '0;
      if (o_pend) begin
        o_pend = 0;
        o_busy = 0;
        if (!rst_i) begin
          exp_we = 1;
          exp_a  = o_paddr;
          exp_d  = o_pdata;
          ref_mem[o_paddr] = o_pdata;
          sb.push_back('{id: o_pid, due: cycle + 1, is_read: 0, data: '0});
        end
      end

      if (exp_ready != 2'b00) begin
        id = exp_ready[1] ? 1 : 0;
        o_last = id;
        if (req_we_i[id]) begin
          if (req_be_i[id] == 4'hF) begin
            exp_we = 1;
            exp_a  = req_addr_i[id];
            exp_d  = req_wdata_i[id];
            ref_mem[req_addr_i[id]] = req_wdata_i[id];
            sb.push_back('{id: id, due: cycle + 1, is_read: 0, data: '0});
          end else if (req_be_i[id] == 4'h0) begin
            sb.push_back('{id: id, due: cycle + 1, is_read: 0, data: '0});
          end else begin
            o_pend  = 1;
            o_busy  = 1;
            o_pid   = id;
            o_paddr = req_addr_i[id];
            o_pdata = refMerge(ref_mem[req_addr_i[id]], req_wdata_i[id], req_be_i[id]);
          end
        end else begin
          sb.push_back('{id: id, due: cycle + 1, is_read: 1, data: ref_mem[req_addr_i[id]]});
        end
      end

      checkOutput("mem_we", {31'd0, mem_we_o}, {31'd0, exp_we});
      if (exp_we) begin
        checkOutput("mem_addr", {22'd0, mem_a_o}, {22'd0, exp_a});
        checkOutput("mem_wdata", mem_wd_o, exp_d);
      end
      if (rst_i) o_last = 1;
    end
  end

  // Monitor: whenever the DUT signals a completion, pop the oldest expected
  // response and compare requester, timing and read data.
  always @(negedge clk_i) begin
    exp_t e;
    if (cycle > 0) begin
      if (rsp_valid_o != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", {30'd0, rsp_valid_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_valid", {30'd0, rsp_valid_o}, 32'd1 << e.id);
          checkOutput("rsp_cycle", cycle, e.due);
          if (e.is_read) begin
            checkOutput("rsp_rdata", rsp_rdata_o, e.data);
            last_rdata = e.data;
          end else begin
            checkOutput("rsp_rdata_hold", rsp_rdata_o, last_rdata);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cycle) begin
        e = sb.pop_front();
        checkOutput("rsp_missing", {30'd0, rsp_valid_o}, 32'd1 << e.id);
      end
      if (rst_i) last_rdata = '0;
    end
  end

  initial begin
    logic [1:0]  v;
    logic [1:0]  we;
    logic [9:0]  a [2];
    logic [31:0] d [2];
    logic [3:0]  b [2];
    rst_i       = 1'b1;
    req_valid_i = 2'b00;
    req_we_i    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr_i[i]  = '0;
      req_wdata_i[i] = '0;
      req_be_i[i]    = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;  ref_mem[5] = 32'hDEADBEEF;
    mem[7] = 32'h11223344;  ref_mem[7] = 32'h11223344;
    mem[9] = 32'hCAFEF00D;  ref_mem[9] = 32'hCAFEF00D;

    repeat (3) idleCycle(1'b1);
    idleCycle(1'b0);

    // Read of a known word by the core port.
    applyStimulus(1'b0, 2'b01, 2'b00, 10'd5, '0, 4'hF, '0, '0, '0);
    idleCycle(1'b0);
    // Partial write by the loader port.
    applyStimulus(1'b0, 2'b10, 2'b10, '0, '0, '0, 10'd7, 32'hAABBCCDD, 4'b0101);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("mem7_merged", mem[7], 32'h11BB33DD);
    // Four cycles of contention with full-word reads.
    repeat (4) applyStimulus(1'b0, 2'b11, 2'b00, 10'd10, '0, 4'hF, 10'd11, '0, 4'hF);
    idleCycle(1'b0);
    // Back-to-back full writes from the core port.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 2'b01, 2'b01, 10'(i), 32'h1000_0000 + i, 4'hF, '0, '0, '0);
    end
    idleCycle(1'b0);
    // Write with no byte enables.
    applyStimulus(1'b0, 2'b01, 2'b01, 10'd4, 32'h55555555, 4'h0, '0, '0, '0);
    idleCycle(1'b0);
    // Reset lands during the read-modify-write cycle.
    applyStimulus(1'b0, 2'b01, 2'b01, 10'd9, 32'h12345678, 4'b0011, '0, '0, '0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("mem9_kept", mem[9], 32'hCAFEF00D);

    // Randomised traffic over a small address window to force collisions.
    for (int n = 0; n < 600; n++) begin
      v  = 2'($urandom_range(0, 3));
      we = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        a[k] = 10'($urandom_range(0, 15));
        d[k] = $urandom;
        case ($urandom_range(0, 3))
          0:       b[k] = 4'hF;
          1:       b[k] = 4'h0;
          default: b[k] = 4'($urandom_range(0, 15));
        endcase
      end
      applyStimulus(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, v, we,
                    a[0], d[0], b[0], a[1], d[1], b[1]);
    end

    repeat (4) idleCycle(1'b0);
    checkOutput("queue_drained", sb.size(), 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
